// File: rtl/dma_pkg.sv
// Shared DMA constants and FSM encoding, also used by the CPU-side stall logic
// for its DMA_LENGTH-1 terminal compare.
package dma_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int DMA_LENGTH = 12;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_XFER,
        ST_WAIT_ACK,
        ST_DONE
    } dma_fsm_e;

    function automatic logic is_last_word(input logic [CNT_W-1:0] cnt, input int length);
        return cnt == CNT_W'(length - 1);
    endfunction

endpackage

// File: rtl/dma_word_counter.sv
// Transfer word counter: clear, increment or hold, with a last-word flag.
module dma_word_counter
    import dma_pkg::*;
#(
    parameter int LENGTH = DMA_LENGTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    assign last = is_last_word(count, LENGTH);

endmodule

// File: rtl/dma_controller.sv
// Device-to-memory DMA engine: requests the bus, copies DMA_LENGTH device words
// to cmd_addr onward, and raises a one-cycle completion interrupt.
//
//  state       | meaning
//  ST_IDLE     | waiting for cmd_valid; BR low
//  ST_REQUEST  | BR high, waiting for BG
//  ST_XFER     | capture dev_data, raise mem_write
//  ST_WAIT_ACK | mem_write held until mem_ack
//  ST_DONE     | last word written; pulse dma_done and return to idle
module dma_controller
    import dma_pkg::*;
#(
    parameter int WORD_SIZE  = dma_pkg::WORD_SIZE,
    parameter int DMA_LENGTH = dma_pkg::DMA_LENGTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [WORD_SIZE-1:0] cmd_addr,
    input  logic                 BG,
    input  logic [WORD_SIZE-1:0] dev_data,
    input  logic                 mem_ack,
    output logic                 BR,
    output logic [3:0]           dma_state,
    output logic [3:0]           dev_offset,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data,
    output logic                 mem_write,
    output logic                 dma_done
);

    dma_fsm_e             state;
    logic [WORD_SIZE-1:0] base_addr;
    logic                 cnt_clear;
    logic                 cnt_incr;
    logic                 cnt_last;

    // The counter only advances on an accepted write, so a bus pause replays the word.
    assign cnt_clear = (state == ST_IDLE) && cmd_valid;
    assign cnt_incr  = (state == ST_WAIT_ACK) && mem_ack && !cnt_last;

    dma_word_counter #(
        .LENGTH (DMA_LENGTH)
    ) u_word_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .incr  (cnt_incr),
        .count (dma_state),
        .last  (cnt_last)
    );

    assign dev_offset = dma_state;
    assign mem_addr   = base_addr + WORD_SIZE'(dma_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            base_addr <= '0;
            mem_data  <= '0;
            mem_write <= 1'b0;
            BR        <= 1'b0;
            dma_done  <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    BR        <= 1'b0;
                    mem_write <= 1'b0;
                    if (cmd_valid) begin
                        base_addr <= cmd_addr;
                        BR        <= 1'b1;
                        state     <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    BR <= 1'b1;
                    if (BG) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!BG) begin
                        state <= ST_REQUEST;
                    end else begin
                        mem_data  <= dev_data;
                        mem_write <= 1'b1;
                        state     <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (mem_ack) begin
                        // An ack coinciding with a grant drop still completes the word.
                        mem_write <= 1'b0;
                        if (cnt_last) begin
                            BR    <= 1'b0;
                            state <= ST_DONE;
                        end else if (BG) begin
                            state <= ST_XFER;
                        end else begin
                            state <= ST_REQUEST;
                        end
                    end else if (!BG) begin
                        mem_write <= 1'b0;
                        state     <= ST_REQUEST;
                    end
                end
                ST_DONE: begin
                    BR       <= 1'b0;
                    dma_done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 Parameter WORD_SIZE, default 16, data/address width.
REQ-002 Parameter DMA_LENGTH, default 12, words per transfer.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  CPU-issued DMA command strobe, sampled only in IDLE.
REQ-006 cmd_addr  in  WORD_SIZE  destination base address in memory.
REQ-007 BG  in  1  bus grant from the CPU.
REQ-008 dev_data  in  WORD_SIZE  device word selected by dev_offset.
REQ-009 mem_ack  in  1  memory accepted the current write.
REQ-010 BR  out  1  bus request to the CPU hazard/stall logic.
REQ-011 dma_state  out  4  transfer word counter, read by the CPU stall FSM.
REQ-012 dev_offset  out  4  index of the device word being transferred, equal to dma_state.
REQ-013 mem_addr  out  WORD_SIZE  write address, cmd_addr + dma_state.
REQ-014 mem_data  out  WORD_SIZE  write data, dev_data registered at word start.
REQ-015 mem_write  out  1  memory write request.
REQ-016 dma_done  out  1  one-cycle completion interrupt to the CPU.

Function
REQ-017 FSM states: IDLE, REQUEST, XFER, WAIT_ACK, DONE.
REQ-018 IDLE: cmd_valid=1 latches cmd_addr, clears dma_state to 0, and goes to REQUEST; otherwise the FSM stays in IDLE.
REQ-019 REQUEST: BR=1; the FSM holds until BG=1, then goes to XFER on the next edge.
REQ-020 XFER: the FSM registers mem_data<=dev_data, sets mem_write=1, and goes to WAIT_ACK, one cycle per word.
REQ-021 WAIT_ACK: mem_write stays 1 until mem_ack=1.
REQ-021a On ack with dma_state<DMA_LENGTH-1: the FSM increments dma_state and returns to XFER.
REQ-021b On ack with dma_state=DMA_LENGTH-1: the FSM goes to DONE with dma_state held at 11.
REQ-022 BR stays 1 from REQUEST entry through the cycle dma_state reaches DMA_LENGTH-1 and DONE is entered; BR=0 in DONE and IDLE.
REQ-023 DONE: dma_done=1 for exactly one cycle, then IDLE; dma_state holds 11 until the next command, so the CPU FSM sees 11.
REQ-024 If BG deasserts in XFER or WAIT_ACK, the FSM pauses without corrupting dma_state.
REQ-024a On a pause the FSM forces mem_write=0 and returns to REQUEST with BR=1; the current word restarts on re-grant.
REQ-025 The FSM ignores cmd_valid outside IDLE; no queuing.
REQ-026 mem_addr wraps modulo 2^WORD_SIZE when cmd_addr+dma_state overflows.
REQ-027 mem_ack outside WAIT_ACK has no effect.
REQ-028 A simultaneous mem_ack and BG fall in WAIT_ACK counts the word as complete, then the FSM goes to REQUEST (or DONE if it was the last word).
REQ-029 Minimum latency: 2*DMA_LENGTH+2 cycles from the cmd_valid edge to dma_done, with BG already 1 and mem_ack single-cycle.

Reset
REQ-030 reset=1 asynchronously forces IDLE with BR=0, mem_write=0, dma_done=0, dma_state=0, dev_offset=0, mem_addr=0, mem_data=0.
REQ-031 Reset mid-transfer abandons the transfer; no dma_done is issued.

Structure
REQ-032 WORD_SIZE, DMA_LENGTH, and the FSM state encoding live in the shared dma_pkg package, also used by the CPU-side stall logic for the DMA_LENGTH-1 terminal compare.
REQ-033 One sub-module, dma_word_counter, is instantiated: clear, increment and hold controls; 4-bit count; last-word flag.

Verification
REQ-034 Test nominal: cmd_addr=0x0100, BG high, mem_ack single-cycle -> 12 writes to 0x0100..0x010B, dma_done at cycle 26, dma_state=11.
REQ-035 Test grant delay: BG raised 5 cycles after BR -> no mem_write before BG, and dma_done arrives 5 cycles later than in REQ-034.
REQ-036 Test grant drop: BG dropped during word 4 for 3 cycles -> mem_write=0 while BG low, word 4 rewritten at 0x0104, no duplicate count.
REQ-037 Test address wrap: cmd_addr=0xFFFA -> writes 0xFFFA..0xFFFF then 0x0000..0x0005.
REQ-038 Test reset mid-transfer: reset at dma_state=6 -> BR=0, IDLE, no dma_done; a new cmd_valid restarts at word 0.
REQ-039 Test command in flight: cmd_valid pulsed during XFER with cmd_addr=0x0200 -> ignored; all writes still target the original base.
